// File: rtl/calc_pkg.sv
// Shared encodings for the calculator operation sequencer: FSM states,
// datapath opcodes, error codes and a counter-width helper.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GOT_A = 3'd1,
        GOT_B = 3'd2,
        RUN   = 3'd3,
        SHOW  = 3'd4,
        ERR   = 3'd5
    } calc_state_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DIV0 = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, level debouncer and a
// one-cycle press pulse on each debounced rising transition.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The counter only ever reaches CNT_LAST while a change is pending,
    // so the flip also bounds the count.
    assign flip  = (sync_q2 != level) && (cnt == CNT_LAST);
    assign press = flip && !level;

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values of the others, so the synchronizer chain really is two
    // stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Calculator operation sequencer: captures operands and opcode from the
// switches on debounced button presses and runs one start/done transaction.
module calc_seq
    import calc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RES_W     = 16,
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_enter,
    input  logic              btn_exec,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        alu_op,
    output logic              start,
    input  logic              done,
    input  logic [RES_W-1:0]  result,
    output logic [RES_W-1:0]  res_out,
    output logic              res_valid,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic [2:0]        state_o
);

    localparam int               TMO_W    = cnt_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic        enter_ev;
    logic        exec_ev;
    logic [1:0]  btn_level_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_enter),
        .level   (btn_level_unused[0]),
        .press   (enter_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_exec (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_exec),
        .level   (btn_level_unused[1]),
        .press   (exec_ev)
    );

    calc_state_t       state_q, state_d;
    logic [DATA_W-1:0] op_a_d, op_b_d;
    logic [1:0]        alu_op_d, err_d;
    logic              start_d, res_valid_d;
    logic [RES_W-1:0]  res_out_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            alu_op    <= ALU_ADD;
            start     <= 1'b0;
            res_out   <= '0;
            res_valid <= 1'b0;
            err_code  <= ERR_NONE;
            tmo_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            op_a      <= op_a_d;
            op_b      <= op_b_d;
            alu_op    <= alu_op_d;
            start     <= start_d;
            res_out   <= res_out_d;
            res_valid <= res_valid_d;
            err_code  <= err_d;
            tmo_cnt   <= tmo_d;
        end
    end

    always_comb begin
        // NOTE: every next value is defaulted before the case so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        op_a_d      = op_a;
        op_b_d      = op_b;
        alu_op_d    = alu_op;
        start_d     = 1'b0;
        res_out_d   = res_out;
        res_valid_d = res_valid;
        err_d       = err_code;
        tmo_d       = '0;

        case (state_q)
            IDLE: begin
                if (enter_ev) begin
                    op_a_d  = sw;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (enter_ev) begin
                    op_b_d  = sw;
                    state_d = GOT_B;
                end
            end
            GOT_B: begin
                // Enter wins a same-cycle collision; that exec is dropped.
                if (enter_ev) begin
                    op_b_d = sw;
                end else if (exec_ev) begin
                    alu_op_d = sw[1:0];
                    if (sw[1:0] == ALU_DIV && op_b == '0) begin
                        err_d   = ERR_DIV0;
                        state_d = ERR;
                    end else begin
                        start_d = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // done is checked first so it still wins on the expiry cycle.
                if (done) begin
                    res_out_d   = result;
                    res_valid_d = 1'b1;
                    state_d     = SHOW;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_d   = ERR_TMO;
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (enter_ev) begin
                    op_a_d      = sw;
                    res_valid_d = 1'b0;
                    state_d     = GOT_A;
                end
            end
            ERR: begin
                if (enter_ev) begin
                    err_d   = ERR_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == RUN);
    assign state_o = state_q;

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed scenarios plus randomized operation sequences
// checked against a transaction-level model of the sequencer and datapath.
module tb_calc_seq;

    localparam int DATA_W    = 8;
    localparam int RES_W     = 16;
    localparam int DB_CYCLES = 4;
    localparam int TIMEOUT   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              btn_enter = 1'b0;
    logic              btn_exec = 1'b0;
    logic [DATA_W-1:0] sw = '0;
    logic [DATA_W-1:0] op_a, op_b;
    logic [1:0]        alu_op;
    logic              start;
    logic              done;
    logic [RES_W-1:0]  result;
    logic [RES_W-1:0]  res_out;
    logic              res_valid;
    logic [1:0]        err_code;
    logic              busy;
    logic [2:0]        state_o;

    logic dp_done = 1'b0;
    logic force_done = 1'b0;
    logic dp_respond = 1'b0;
    int   dp_lat = 3;

    int total = 0;
    int bad = 0;

    int          start_cnt = 0;
    int          wide_cnt = 0;
    int          busy_cnt = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  st_a = '0, st_b = '0;
    logic [1:0]  st_op = '0;

    assign done = dp_done | force_done;

    calc_seq #(
        .DATA_W(DATA_W), .RES_W(RES_W), .DB_CYCLES(DB_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_exec(btn_exec), .sw(sw),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .start(start), .done(done),
        .result(result), .res_out(res_out), .res_valid(res_valid),
        .err_code(err_code), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Arithmetic the datapath is expected to perform.
    function automatic logic [15:0] dp_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
        case (op)
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) - 16'(b);
            2'd2:    return 16'(a) * 16'(b);
            default: return (b == 8'd0) ? 16'hFFFF : 16'(a) / 16'(b);
        endcase
    endfunction

    // Observers of the launch handshake and RUN occupancy.
    always @(negedge clk) begin
        prev_start <= start;
        if (start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            st_a      <= op_a;
            st_b      <= op_b;
            st_op     <= alu_op;
        end
        if (start === 1'b1 && prev_start === 1'b1) wide_cnt <= wide_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    // Datapath stand-in: answers a start after dp_lat cycles when enabled.
    initial begin : dp_model
        int         wait_n;
        logic [7:0] a_l, b_l;
        logic [1:0] op_l;
        wait_n = -1;
        a_l = '0; b_l = '0; op_l = '0;
        result = '0;
        forever begin
            @(negedge clk);
            dp_done = 1'b0;
            if (wait_n == 0) begin
                dp_done = 1'b1;
                result  = dp_calc(a_l, b_l, op_l);
                wait_n  = -1;
            end else if (wait_n > 0) begin
                wait_n--;
            end
            if (start === 1'b1 && dp_respond) begin
                a_l = op_a; b_l = op_b; op_l = alu_op;
                wait_n = dp_lat - 1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b0;
        btn_enter = 1'b0;
        btn_exec = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Hold one raw button for 'hold' cycles, then let the release settle.
    task automatic press(input bit use_exec, input logic [7:0] val, input int hold);
        sw = val;
        if (use_exec) btn_exec = 1'b1;
        else          btn_enter = 1'b1;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_exec  = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
    endtask

    task automatic wait_leave_run(input string tag);
        int n;
        n = 0;
        while (state_o === 3'd3 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (state_o === 3'd3) begin
            bad++;
            $display("FAIL %s_leave_run: still in RUN after %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_enter = 1'b1; btn_exec = 1'b1; force_done = 1'b1; sw = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b1;
            @(negedge clk);
            total++;
            if ({op_a, op_b, alu_op, start, res_out, res_valid, err_code, busy, state_o} !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got a=%0h b=%0h op=%0h st=%0b res=%0h v=%0b err=%0h busy=%0b state=%0d, want all 0",
                         i, op_a, op_b, alu_op, start, res_out, res_valid, err_code, busy, state_o);
            end
        end
        btn_enter = 1'b0; btn_exec = 1'b0; force_done = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
    endtask

    task automatic test_add();
        int s0, w0;
        do_reset();
        dp_respond = 1'b1; dp_lat = 3;
        press(0, 8'h05, 8);
        press(0, 8'h03, 8);
        s0 = start_cnt; w0 = wide_cnt;
        press(1, 8'h00, 8);
        wait_leave_run("add");
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL add_start_count: got %0d, want 1", start_cnt - s0); end
        total++; if (wide_cnt != w0) begin bad++; $display("FAIL add_start_width: got %0d wide cycles, want 0", wide_cnt - w0); end
        total++; if (st_a !== 8'h05) begin bad++; $display("FAIL add_op_a: got %0h, want 05", st_a); end
        total++; if (st_b !== 8'h03) begin bad++; $display("FAIL add_op_b: got %0h, want 03", st_b); end
        total++; if (st_op !== 2'd0) begin bad++; $display("FAIL add_alu_op: got %0d, want 0", st_op); end
        total++; if (res_out !== 16'h0008) begin bad++; $display("FAIL add_res_out: got %0h, want 0008", res_out); end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL add_res_valid: got %0b, want 1", res_valid); end
        total++; if (state_o !== 3'd4) begin bad++; $display("FAIL add_state: got %0d, want 4", state_o); end
    endtask

    // Runs from SHOW left by test_add.
    task automatic test_chain();
        int s0;
        press(0, 8'h02, 8);
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL chain_state: got %0d, want 1", state_o); end
        total++; if (op_a !== 8'h02) begin bad++; $display("FAIL chain_op_a: got %0h, want 02", op_a); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL chain_res_valid: got %0b, want 0", res_valid); end
        total++; if (res_out !== 16'h0008) begin bad++; $display("FAIL chain_res_out: got %0h, want 0008", res_out); end
        dp_respond = 1'b0;
        press(0, 8'h04, 8);
        press(1, 8'h01, 8);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL chain_busy_before_reset: got %0b, want 1", busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s0 = start_cnt;
        repeat (TIMEOUT + 16) @(negedge clk);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL midrun_reset_state: got %0d, want 0", state_o); end
        total++; if (start_cnt != s0) begin bad++; $display("FAIL midrun_reset_restart: got %0d starts, want 0", start_cnt - s0); end
        total++; if ({busy, err_code, res_valid, op_a} !== '0) begin bad++; $display("FAIL midrun_reset_outputs: got busy=%0b err=%0h v=%0b a=%0h, want 0", busy, err_code, res_valid, op_a); end
    endtask

    task automatic test_div0();
        int s0;
        do_reset();
        press(0, 8'h09, 8);
        press(0, 8'h00, 8);
        s0 = start_cnt;
        press(1, 8'h03, 8);
        total++; if (start_cnt != s0) begin bad++; $display("FAIL div0_start: got %0d starts, want 0", start_cnt - s0); end
        total++; if (err_code !== 2'd1) begin bad++; $display("FAIL div0_err: got %0d, want 1", err_code); end
        total++; if (state_o !== 3'd5) begin bad++; $display("FAIL div0_state: got %0d, want 5", state_o); end
        press(0, 8'h5A, 8);
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL div0_clear_err: got %0d, want 0", err_code); end
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL div0_clear_state: got %0d, want 0", state_o); end
        total++; if (op_a !== 8'h09) begin bad++; $display("FAIL div0_clear_op_a: got %0h, want 09", op_a); end
    endtask

    task automatic test_timeout();
        int s0, b0;
        do_reset();
        dp_respond = 1'b0;
        press(0, 8'h10, 8);
        press(0, 8'h10, 8);
        s0 = start_cnt; b0 = busy_cnt;
        press(1, 8'h02, 8);
        wait_leave_run("tmo");
        total++; if (busy_cnt - b0 != TIMEOUT) begin bad++; $display("FAIL tmo_run_cycles: got %0d, want %0d", busy_cnt - b0, TIMEOUT); end
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL tmo_start_count: got %0d, want 1", start_cnt - s0); end
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL tmo_err: got %0d, want 2", err_code); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %0b, want 0", busy); end
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        total++; if (state_o !== 3'd5) begin bad++; $display("FAIL late_done_state: got %0d, want 5", state_o); end
        total++; if ({res_valid, res_out} !== '0) begin bad++; $display("FAIL late_done_result: got v=%0b res=%0h, want 0", res_valid, res_out); end
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL late_done_err: got %0d, want 2", err_code); end
    endtask

    task automatic test_debounce();
        int lat, s0;
        do_reset();
        sw = 8'h77;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        total++; if ({state_o, op_a} !== '0) begin bad++; $display("FAIL glitch_ignored: got state=%0d a=%0h, want 0", state_o, op_a); end
        sw = 8'h3C;
        btn_enter = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (lat == 0 && state_o === 3'd1) lat = k;
        end
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (lat != 2 + DB_CYCLES) begin bad++; $display("FAIL press_latency: got %0d, want %0d", lat, 2 + DB_CYCLES); end
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL press_single_capture: got state %0d, want 1", state_o); end
        total++; if (op_a !== 8'h3C) begin bad++; $display("FAIL press_op_a: got %0h, want 3c", op_a); end
        press(0, 8'h11, 8);
        s0 = start_cnt;
        sw = 8'h22;
        btn_enter = 1'b1;
        btn_exec = 1'b1;
        repeat (8) @(negedge clk);
        btn_enter = 1'b0;
        btn_exec = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
        total++; if (op_b !== 8'h22) begin bad++; $display("FAIL collide_op_b: got %0h, want 22", op_b); end
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL collide_state: got %0d, want 2", state_o); end
        total++; if (start_cnt != s0) begin bad++; $display("FAIL collide_start: got %0d starts, want 0", start_cnt - s0); end
        total++; if (alu_op !== 2'd0) begin bad++; $display("FAIL collide_alu_op: got %0d, want 0", alu_op); end
    endtask

    task automatic test_random();
        logic [7:0]  m_a, m_b, a, b;
        logic [1:0]  m_op, op;
        logic [15:0] m_res;
        logic        m_valid;
        int          m_state, m_err, s0, exp_starts, w0;
        bit          respond;
        do_reset();
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
        m_state = 0; m_err = 0;
        w0 = wide_cnt;
        for (int it = 0; it < 25; it++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            op = 2'($urandom);
            respond = ($urandom_range(0, 4) != 0);
            dp_respond = respond;
            dp_lat = $urandom_range(1, 8);
            if (m_state == 5) begin
                press(0, 8'($urandom), 8);
                m_state = 0; m_err = 0;
            end
            press(0, a, 8);
            m_a = a; m_valid = 1'b0; m_state = 1;
            press(0, b, 8);
            m_b = b; m_state = 2;
            s0 = start_cnt;
            press(1, {6'($urandom), op}, 8);
            m_op = op;
            if (op == 2'd3 && b == 8'd0) begin
                exp_starts = 0; m_state = 5; m_err = 1;
            end else if (respond) begin
                exp_starts = 1; m_state = 4; m_res = dp_calc(a, b, op); m_valid = 1'b1;
            end else begin
                exp_starts = 1; m_state = 5; m_err = 2;
            end
            wait_leave_run("rand");
            total++; if (state_o !== 3'(m_state)) begin bad++; $display("FAIL rand%0d_state: got %0d, want %0d", it, state_o, m_state); end
            total++; if (err_code !== 2'(m_err)) begin bad++; $display("FAIL rand%0d_err: got %0d, want %0d", it, err_code, m_err); end
            total++; if (res_valid !== m_valid) begin bad++; $display("FAIL rand%0d_valid: got %0b, want %0b", it, res_valid, m_valid); end
            total++; if (res_out !== m_res) begin bad++; $display("FAIL rand%0d_res_out: got %0h, want %0h", it, res_out, m_res); end
            total++; if (op_a !== m_a || op_b !== m_b) begin bad++; $display("FAIL rand%0d_operands: got %0h/%0h, want %0h/%0h", it, op_a, op_b, m_a, m_b); end
            total++; if (alu_op !== m_op) begin bad++; $display("FAIL rand%0d_alu_op: got %0d, want %0d", it, alu_op, m_op); end
            total++; if (start_cnt - s0 != exp_starts) begin bad++; $display("FAIL rand%0d_starts: got %0d, want %0d", it, start_cnt - s0, exp_starts); end
            if (exp_starts == 1) begin
                total++; if (st_a !== m_a || st_b !== m_b || st_op !== m_op) begin bad++; $display("FAIL rand%0d_launch: got %0h/%0h/%0d, want %0h/%0h/%0d", it, st_a, st_b, st_op, m_a, m_b, m_op); end
            end
        end
        total++; if (wide_cnt != w0) begin bad++; $display("FAIL rand_start_width: got %0d wide cycles, want 0", wide_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_div0();
        test_timeout();
        test_debounce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
